// File: rtl/fp_cast_requester_pkg.sv
// Shared APU cluster constants, the cast-response record and counter sizing helpers
// used by the cast requester and its response FIFO.
package apu_cluster_package;

   localparam int FP_WIDTH            = 32;
   localparam int NDSFLAGS_CAST       = 3;
   localparam int NUSFLAGS_CAST       = 5;
   localparam int CAST_REQ_FIFO_DEPTH = 4;
   localparam int CAST_TAG_WIDTH      = 4;

   typedef struct packed {
      logic [FP_WIDTH-1:0]       res;
      logic [CAST_TAG_WIDTH-1:0] tag;
      logic [NUSFLAGS_CAST-1:0]  status;
   } cast_resp_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cntWidth(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   // Bits needed to index n entries (never zero, so a 1-deep FIFO still has a pointer).
   function automatic int ptrWidth(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fp_cast_requester_resp_fifo.sv
// Response FIFO for cast results: register-array storage, head read straight from the array,
// and a push is accepted on a full FIFO only when a pop happens in the same cycle.
module fp_resp_fifo
   import apu_cluster_package::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [cntWidth(DEPTH)-1:0] o_count
);

   localparam int PTR_W = ptrWidth(DEPTH);
   localparam int CNT_W = cntWidth(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= nextPtr(r_wptr);
         if (w_pop)  r_rptr <= nextPtr(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/fp_cast_requester.sv
// Initiator-side adapter for the shared FP cast unit: credit-limited req/gnt intake, one-cycle
// issue register toward the unit, and a response FIFO drained by the core on valid/ready.
module fp_cast_requester
   import apu_cluster_package::*;
#(
   parameter int C_CAST_LAT = 0,
   parameter int TAG_WIDTH  = 4,
   parameter int RND_WIDTH  = NDSFLAGS_CAST,
   parameter int STAT_WIDTH = NUSFLAGS_CAST,
   parameter int FIFO_DEPTH = CAST_REQ_FIFO_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  Req_i,
   output logic                  Gnt_o,
   input  logic                  F2I_i,
   input  logic [FP_WIDTH-1:0]   OpA_i,
   input  logic [TAG_WIDTH-1:0]  Tag_i,
   input  logic [RND_WIDTH-1:0]  Rnd_i,
   output logic                  En_o,
   output logic                  F2I_o,
   output logic [FP_WIDTH-1:0]   OpA_o,
   output logic [TAG_WIDTH-1:0]  Tag_o,
   output logic [RND_WIDTH-1:0]  Rnd_o,
   input  logic                  Ready_i,
   input  logic                  Valid_i,
   input  logic [FP_WIDTH-1:0]   Res_i,
   input  logic [TAG_WIDTH-1:0]  UTag_i,
   input  logic [STAT_WIDTH-1:0] Status_i,
   output logic                  Rvalid_o,
   input  logic                  Rready_i,
   output logic [FP_WIDTH-1:0]   RRes_o,
   output logic [TAG_WIDTH-1:0]  RTag_o,
   output logic [STAT_WIDTH-1:0] RStatus_o,
   output logic                  Err_o
);

   localparam int RES_W = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;
   localparam int RSV_W = cntWidth(FIFO_DEPTH);
   // In-flight ops are bounded by both the credit pool and the unit pipeline length.
   localparam int INF_W = cntWidth((FIFO_DEPTH > C_CAST_LAT + 1) ? FIFO_DEPTH : C_CAST_LAT + 1);
   localparam logic [RSV_W-1:0] RSV_MAX = RSV_W'(FIFO_DEPTH);

   logic [RSV_W-1:0]      r_reserved;
   logic [INF_W-1:0]      r_inflight;
   logic                  r_en;
   logic                  r_f2i;
   logic [FP_WIDTH-1:0]   r_opA;
   logic [TAG_WIDTH-1:0]  r_tag;
   logic [RND_WIDTH-1:0]  r_rnd;
   logic                  r_err;

   logic                  w_gnt;
   logic                  w_pop;
   logic                  w_matched;
   logic                  w_push;
   logic                  w_errStale;
   logic                  w_errFull;
   logic                  w_full;
   logic                  w_empty;
   logic [RES_W-1:0]      w_pushData;
   logic [RES_W-1:0]      w_headData;

   assign w_gnt      = Req_i & Ready_i & (r_reserved < RSV_MAX) & ~rst_i;
   assign w_pop      = ~w_empty & Rready_i;
   // A result is legitimate only if an issued op is outstanding or being issued right now.
   assign w_matched  = Valid_i & ((r_inflight != '0) | r_en);
   assign w_push     = w_matched & (~w_full | w_pop);
   assign w_errStale = Valid_i & ~w_matched;
   assign w_errFull  = w_matched & w_full & ~w_pop;
   assign w_pushData = {Res_i, UTag_i, Status_i};

   fp_resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RES_W)
   ) u_respFifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_data  (w_pushData),
      .i_pop   (w_pop),
      .o_data  (w_headData),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count ()
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_reserved <= '0;
         r_inflight <= '0;
         r_en       <= 1'b0;
         r_f2i      <= 1'b0;
         r_opA      <= '0;
         r_tag      <= '0;
         r_rnd      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_en <= w_gnt;
         // Operands hold between issues; the unit only looks at them while En_o is high.
         if (w_gnt) begin
            r_f2i <= F2I_i;
            r_opA <= OpA_i;
            r_tag <= Tag_i;
            r_rnd <= Rnd_i;
         end
         case ({w_gnt, w_pop})
            2'b10:   r_reserved <= r_reserved + RSV_W'(1);
            2'b01:   r_reserved <= r_reserved - RSV_W'(1);
            default: r_reserved <= r_reserved;
         endcase
         case ({r_en, w_matched})
            2'b10:   r_inflight <= r_inflight + INF_W'(1);
            2'b01:   r_inflight <= r_inflight - INF_W'(1);
            default: r_inflight <= r_inflight;
         endcase
         r_err <= r_err | w_errStale | w_errFull;
      end
   end

   assign Gnt_o    = w_gnt;
   assign En_o     = r_en;
   assign F2I_o    = r_f2i;
   assign OpA_o    = r_opA;
   assign Tag_o    = r_tag;
   assign Rnd_o    = r_rnd;
   assign Rvalid_o = ~w_empty;
   assign Err_o    = r_err;
   assign {RRes_o, RTag_o, RStatus_o} = w_headData;

endmodule

// File: tb/tb_fp_cast_requester.sv
// Directed bench for fp_cast_requester: a zero-latency instance for the single-op path and a
// one-cycle-latency instance for streaming, credit back-pressure, error and reset scenarios.
module tb_fp_cast_requester;
   import apu_cluster_package::*;

   localparam int TW = 4;
   localparam int RW = NDSFLAGS_CAST;
   localparam int SW = NUSFLAGS_CAST;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   assertCount = 0;
   int   failCount   = 0;

   // Instance 0: C_CAST_LAT = 0
   logic          req0, f2i0, gnt0, en0, f2iO0, valid0, rvalid0, err0;
   logic [31:0]   opA0, opAO0, res0, rres0;
   logic [TW-1:0] tag0, tagO0, utag0, rtag0;
   logic [RW-1:0] rnd0, rndO0;
   logic [SW-1:0] stat0, rstat0;

   // Instance 1: C_CAST_LAT = 1
   logic          req1, gnt1, en1, f2iO1, valid1, rvalid1, rready1, err1, inject1;
   logic [31:0]   opA1, opAO1, res1, rres1;
   logic [TW-1:0] tag1, tagO1, utag1, rtag1;
   logic [RW-1:0] rndO1;
   logic [SW-1:0] stat1, rstat1;

   logic          u1Valid = 1'b0;
   logic          u1F2i   = 1'b0;
   logic [31:0]   u1OpA   = '0;
   logic [TW-1:0] u1Tag   = '0;

   // Behavioural cast unit: positive ints to single precision and back, small magnitudes only.
   function automatic logic [31:0] castModel(input logic f2i, input logic [31:0] x);
      logic [31:0] r;
      int          msb;
      int          sh;
      r = '0;
      if (f2i) begin
         sh = 150 - int'(x[30:23]);
         if (sh >= 0 && sh <= 23) r = {8'h00, 1'b1, x[22:0]} >> sh;
      end else if (x != '0) begin
         msb = 0;
         for (int i = 0; i < 32; i++) if (x[i]) msb = i;
         if (msb <= 23) r = {1'b0, 8'(127 + msb), 23'(x << (23 - msb))};
      end
      return r;
   endfunction

   assign valid0 = en0;
   assign res0   = castModel(f2iO0, opAO0);
   assign utag0  = tagO0;
   assign stat0  = {{(SW-1){1'b0}}, f2iO0};

   // One-stage unit pipeline; the cluster resets it together with the requester.
   always @(posedge clk) begin
      u1Valid <= rst ? 1'b0 : en1;
      u1F2i   <= f2iO1;
      u1OpA   <= opAO1;
      u1Tag   <= tagO1;
   end
   assign valid1 = u1Valid | inject1;
   assign res1   = castModel(u1F2i, u1OpA);
   assign utag1  = u1Tag;
   assign stat1  = {{(SW-1){1'b0}}, u1F2i};

   fp_cast_requester #(.C_CAST_LAT(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .Req_i(req0), .Gnt_o(gnt0), .F2I_i(f2i0), .OpA_i(opA0),
      .Tag_i(tag0), .Rnd_i(rnd0), .En_o(en0), .F2I_o(f2iO0), .OpA_o(opAO0), .Tag_o(tagO0),
      .Rnd_o(rndO0), .Ready_i(1'b1), .Valid_i(valid0), .Res_i(res0), .UTag_i(utag0),
      .Status_i(stat0), .Rvalid_o(rvalid0), .Rready_i(1'b1), .RRes_o(rres0), .RTag_o(rtag0),
      .RStatus_o(rstat0), .Err_o(err0)
   );

   // A slot stays reserved from the grant edge to the pop edge (latency + 2 cycles), so a
   // 4-deep FIFO streams one op per cycle with a one-cycle unit.
   fp_cast_requester #(.C_CAST_LAT(1), .FIFO_DEPTH(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .Req_i(req1), .Gnt_o(gnt1), .F2I_i(1'b0), .OpA_i(opA1),
      .Tag_i(tag1), .Rnd_i('0), .En_o(en1), .F2I_o(f2iO1), .OpA_o(opAO1), .Tag_o(tagO1),
      .Rnd_o(rndO1), .Ready_i(1'b1), .Valid_i(valid1), .Res_i(res1), .UTag_i(utag1),
      .Status_i(stat1), .Rvalid_o(rvalid1), .Rready_i(rready1), .RRes_o(rres1), .RTag_o(rtag1),
      .RStatus_o(rstat1), .Err_o(err1)
   );

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
      end
   endtask

   // Inputs change at the falling edge; outputs are checked 1 ns later, well before the rising edge.
   task automatic applyStimulus(input logic r, input logic [TW-1:0] t, input logic [31:0] a,
                                input logic rr);
      @(negedge clk);
      req1    = r;
      tag1    = t;
      opA1    = a;
      rready1 = rr;
      #1;
   endtask

   logic [31:0] floatOf [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
   logic [TW-1:0] drainTag [4] = '{4'd10, 4'd11, 4'd14, 4'd15};
   logic [31:0]   drainRes [4] = '{32'h4040_0000, 32'h4080_0000, 32'h4110_0000, 32'h4120_0000};

   initial begin
      rst = 1'b1; inject1 = 1'b0;
      req0 = 1'b0; f2i0 = 1'b0; opA0 = '0; tag0 = '0; rnd0 = '0;
      req1 = 1'b1; opA1 = '0; tag1 = '0; rready1 = 1'b1;

      // Reset state, with a request pending to show reset masks the grant
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset gnt1", 32'(gnt1), 32'd0);
      checkOutput("reset en1", 32'(en1), 32'd0);
      checkOutput("reset rvalid1", 32'(rvalid1), 32'd0);
      checkOutput("reset err1", 32'(err1), 32'd0);
      checkOutput("reset opA1", opAO1, 32'd0);
      checkOutput("reset en0", 32'(en0), 32'd0);
      checkOutput("reset rvalid0", 32'(rvalid0), 32'd0);

      // Single int->float op through the zero-latency instance
      applyStimulus(1'b0, '0, '0, 1'b1);
      rst = 1'b0; req0 = 1'b1; opA0 = 32'd5; f2i0 = 1'b0; tag0 = 4'd3; rnd0 = 3'd2;
      #1;
      checkOutput("single gnt0", 32'(gnt0), 32'd1);
      checkOutput("single en0 t", 32'(en0), 32'd0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      req0 = 1'b0; opA0 = '0;
      checkOutput("single en0 t+1", 32'(en0), 32'd1);
      checkOutput("single opA_o", opAO0, 32'd5);
      checkOutput("single tag_o", 32'(tagO0), 32'd3);
      checkOutput("single rnd_o", 32'(rndO0), 32'd2);
      checkOutput("single rvalid0 t+1", 32'(rvalid0), 32'd0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("single en0 t+2", 32'(en0), 32'd0);
      checkOutput("single rvalid0 t+2", 32'(rvalid0), 32'd1);
      checkOutput("single rres0", rres0, 32'h40A0_0000);
      checkOutput("single rtag0", 32'(rtag0), 32'd3);
      checkOutput("single opA_o hold", opAO0, 32'd5);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("single rvalid0 popped", 32'(rvalid0), 32'd0);

      // Float->int op: 8.0 -> 8
      applyStimulus(1'b0, '0, '0, 1'b1);
      req0 = 1'b1; f2i0 = 1'b1; opA0 = 32'h4100_0000; tag0 = 4'd9; rnd0 = 3'd1;
      #1;
      checkOutput("f2i gnt0", 32'(gnt0), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      req0 = 1'b0;
      checkOutput("f2i f2i_o", 32'(f2iO0), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("f2i rres0", rres0, 32'd8);
      checkOutput("f2i rtag0", 32'(rtag0), 32'd9);
      checkOutput("f2i rstatus0", 32'(rstat0), 32'd1);

      // Burst of 8 with the core always ready: 8 consecutive grants, results in order
      for (int c = 0; c < 12; c++) begin
         applyStimulus(c < 8, c[3:0], 32'(c + 1), 1'b1);
         checkOutput("burst gnt1", 32'(gnt1), 32'(c < 8));
         if (c >= 3 && c <= 10) begin
            checkOutput("burst rvalid1", 32'(rvalid1), 32'd1);
            checkOutput("burst rtag1", 32'(rtag1), 32'(c - 3));
            checkOutput("burst rres1", rres1, floatOf[c - 3]);
         end else begin
            checkOutput("burst rvalid1 idle", 32'(rvalid1), 32'd0);
         end
      end

      // Core stalled: six requests, only four credits
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 4'(8 + i), 32'(i + 1), 1'b0);
         checkOutput("stall gnt1", 32'(gnt1), 32'(i < 4));
      end
      applyStimulus(1'b1, 4'd14, 32'd9, 1'b0);
      checkOutput("full gnt1", 32'(gnt1), 32'd0);
      checkOutput("full rvalid1", 32'(rvalid1), 32'd1);
      checkOutput("full head", 32'(rtag1), 32'd8);
      applyStimulus(1'b1, 4'd14, 32'd9, 1'b0);
      checkOutput("full head stable", 32'(rtag1), 32'd8);
      applyStimulus(1'b1, 4'd14, 32'd9, 1'b1);
      checkOutput("pop gnt1 still blocked", 32'(gnt1), 32'd0);
      // Pop and grant in the same cycle
      applyStimulus(1'b1, 4'd14, 32'd9, 1'b1);
      checkOutput("pop+grant gnt1", 32'(gnt1), 32'd1);
      checkOutput("pop+grant head", 32'(rtag1), 32'd9);
      applyStimulus(1'b1, 4'd15, 32'd10, 1'b0);
      checkOutput("credit after pop+grant", 32'(gnt1), 32'd1);
      checkOutput("head advanced", 32'(rtag1), 32'd10);
      applyStimulus(1'b1, 4'd0, 32'd0, 1'b0);
      checkOutput("credits exhausted", 32'(gnt1), 32'd0);
      checkOutput("no err1", 32'(err1), 32'd0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1);
         checkOutput("drain rtag1", 32'(rtag1), 32'(drainTag[i]));
         checkOutput("drain rres1", rres1, drainRes[i]);
      end

      // Stray result with nothing in flight
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("pre-inject rvalid1", 32'(rvalid1), 32'd0);
      checkOutput("pre-inject err1", 32'(err1), 32'd0);
      inject1 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0);
      inject1 = 1'b0;
      checkOutput("inject err1", 32'(err1), 32'd1);
      checkOutput("inject dropped", 32'(rvalid1), 32'd0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("err1 sticky", 32'(err1), 32'd1);

      // Reset with three results buffered and one in flight
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'(1 + i), 32'(i + 1), 1'b0);
         checkOutput("prefill gnt1", 32'(gnt1), 32'd1);
      end
      applyStimulus(1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("prefill head", 32'(rtag1), 32'd1);
      checkOutput("prefill valid in flight", 32'(valid1), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b1, 4'd5, 32'd5, 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("post-reset rvalid1", 32'(rvalid1), 32'd0);
      checkOutput("post-reset err1", 32'(err1), 32'd0);
      checkOutput("post-reset gnt1", 32'(gnt1), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("post-reset en1", 32'(en1), 32'd1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("post-reset result tag", 32'(rtag1), 32'd5);
      checkOutput("post-reset result", rres1, 32'h40A0_0000);
      checkOutput("post-reset no err1", 32'(err1), 32'd0);
      checkOutput("final err0", 32'(err0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
